// File: rtl/drive_pkg.sv
// Shared drive-command definitions: one-hot direction codes and ASCII command bytes.
package drive_pkg;

  localparam int unsigned DIR_W  = 7;
  localparam int unsigned DUTY_W = 8;
  localparam int unsigned BYTE_W = 8;

  localparam logic [DIR_W-1:0] DIR_FORWARD  = 7'b0000001;
  localparam logic [DIR_W-1:0] DIR_IDLE     = 7'b0000010;
  localparam logic [DIR_W-1:0] DIR_BACKWARD = 7'b0000100;
  localparam logic [DIR_W-1:0] DIR_LEFT     = 7'b0001000;
  localparam logic [DIR_W-1:0] DIR_RIGHT    = 7'b0010000;
  localparam logic [DIR_W-1:0] DIR_ACC      = 7'b0100000;
  localparam logic [DIR_W-1:0] DIR_DEC      = 7'b1000000;

  localparam logic [BYTE_W-1:0] CMD_FORWARD  = 8'h77;  // 'w'
  localparam logic [BYTE_W-1:0] CMD_BACKWARD = 8'h73;  // 's'
  localparam logic [BYTE_W-1:0] CMD_LEFT     = 8'h61;  // 'a'
  localparam logic [BYTE_W-1:0] CMD_RIGHT    = 8'h64;  // 'd'
  localparam logic [BYTE_W-1:0] CMD_IDLE     = 8'h20;  // ' '
  localparam logic [BYTE_W-1:0] CMD_ACC      = 8'h71;  // 'q'
  localparam logic [BYTE_W-1:0] CMD_DEC      = 8'h65;  // 'e'

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // Only A..Z are folded; everything else passes through untouched.
  function automatic logic [BYTE_W-1:0] to_lower(input logic [BYTE_W-1:0] c);
    return (c >= 8'h41 && c <= 8'h5A) ? c + 8'h20 : c;
  endfunction

endpackage

// File: rtl/cmd_uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, start-bit glitch filter, LSB-first shift, stop check.
module cmd_uart_rx
  import drive_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1085
) (
  input  logic              clk_125mhz,
  input  logic              reset,
  input  logic              rx_serial,
  output logic [BYTE_W-1:0] data_byte,
  output logic              byte_stb,
  output logic              frame_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic              meta_q, meta_d, sync_q, sync_d, prev_q, prev_d;
  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              stb_q, stb_d, ferr_q, ferr_d;

  always_comb begin
    meta_d  = rx_serial;
    sync_d  = meta_q;
    prev_d  = sync_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    stb_d   = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        // Falling edge only, so a low stop bit cannot retrigger a frame.
        if (prev_q && !sync_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {sync_q, shift_q[BYTE_W-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          stb_d   = sync_q;
          ferr_d  = !sync_q;
          state_d = RX_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_125mhz) begin
    if (reset) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      stb_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      stb_q   <= stb_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data_byte = shift_q;
  assign byte_stb  = stb_q;
  assign frame_err = ferr_q;

endmodule

// File: rtl/drive_cmd_rx.sv
// UART drive-command decoder: one-hot direction, saturating PWM duty, link watchdog.
module drive_cmd_rx
  import drive_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT   = 1085,
  parameter int unsigned TIMEOUT_CYCLES = 62_500_000,
  parameter int unsigned DUTY_STEP      = 16
) (
  input  logic              clk_125mhz,
  input  logic              reset,
  input  logic              rx_serial,
  output logic [DIR_W-1:0]  direction,
  output logic [DUTY_W-1:0] duty,
  output logic              cmd_valid,
  output logic              cmd_err,
  output logic              frame_err,
  output logic              timeout
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [BYTE_W-1:0] rx_byte, lc;
  logic              rx_stb;
  logic              dec_hit;
  logic [DIR_W-1:0]  dec_dir;
  logic [DUTY_W:0]   duty_up, duty_dn;

  logic [DIR_W-1:0]  dir_q, dir_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              valid_q, valid_d, cerr_q, cerr_d, tmo_q, tmo_d;

  cmd_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_125mhz (clk_125mhz),
    .reset      (reset),
    .rx_serial  (rx_serial),
    .data_byte  (rx_byte),
    .byte_stb   (rx_stb),
    .frame_err  (frame_err)
  );

  // Byte to direction lookup, case-insensitive.
  always_comb begin
    lc      = to_lower(rx_byte);
    dec_hit = 1'b1;
    dec_dir = DIR_IDLE;
    case (lc)
      CMD_FORWARD:  dec_dir = DIR_FORWARD;
      CMD_BACKWARD: dec_dir = DIR_BACKWARD;
      CMD_LEFT:     dec_dir = DIR_LEFT;
      CMD_RIGHT:    dec_dir = DIR_RIGHT;
      CMD_IDLE:     dec_dir = DIR_IDLE;
      CMD_ACC:      dec_dir = DIR_ACC;
      CMD_DEC:      dec_dir = DIR_DEC;
      default:      dec_hit = 1'b0;
    endcase
  end

  // Bit 8 of the 9-bit result flags overflow (up) or borrow (down).
  assign duty_up = {1'b0, duty_q} + 9'(DUTY_STEP);
  assign duty_dn = {1'b0, duty_q} - 9'(DUTY_STEP);

  always_comb begin
    dir_d   = dir_q;
    duty_d  = duty_q;
    wd_d    = wd_q;
    valid_d = 1'b0;
    cerr_d  = 1'b0;
    tmo_d   = 1'b0;
    if (dir_q == DIR_IDLE) begin
      wd_d = '0;
    end else if (wd_q == WD_LAST) begin
      dir_d  = DIR_IDLE;
      duty_d = '0;
      wd_d   = '0;
      tmo_d  = 1'b1;
    end else begin
      wd_d = wd_q + WD_W'(1);
    end
    // A decoded command overrides a same-cycle watchdog expiry.
    if (rx_stb) begin
      if (dec_hit) begin
        dir_d   = dec_dir;
        valid_d = 1'b1;
        wd_d    = '0;
        tmo_d   = 1'b0;
        if (lc == CMD_ACC)      duty_d = duty_up[DUTY_W] ? 8'hFF : duty_up[DUTY_W-1:0];
        else if (lc == CMD_DEC) duty_d = duty_dn[DUTY_W] ? 8'h00 : duty_dn[DUTY_W-1:0];
        else                    duty_d = duty_q;
      end else begin
        cerr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_125mhz) begin
    if (reset) begin
      dir_q   <= DIR_IDLE;
      duty_q  <= '0;
      wd_q    <= '0;
      valid_q <= 1'b0;
      cerr_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      dir_q   <= dir_d;
      duty_q  <= duty_d;
      wd_q    <= wd_d;
      valid_q <= valid_d;
      cerr_q  <= cerr_d;
      tmo_q   <= tmo_d;
    end
  end

  assign direction = dir_q;
  assign duty      = duty_q;
  assign cmd_valid = valid_q;
  assign cmd_err   = cerr_q;
  assign timeout   = tmo_q;

endmodule

// File: tb/tb_drive_cmd_rx.sv
// Self-checking bench for drive_cmd_rx: vector table, random bytes vs. a command model, watchdog corners.
module tb_drive_cmd_rx;

  localparam int CPB  = 8;
  localparam int TMO  = 1000;
  localparam int STEP = 16;

  logic       clk_125mhz = 1'b0;
  logic       reset;
  logic       rx_serial;
  logic [6:0] direction;
  logic [7:0] duty;
  logic       cmd_valid, cmd_err, frame_err, timeout;

  drive_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TMO), .DUTY_STEP(STEP)) dut (
    .clk_125mhz (clk_125mhz),
    .reset      (reset),
    .rx_serial  (rx_serial),
    .direction  (direction),
    .duty       (duty),
    .cmd_valid  (cmd_valid),
    .cmd_err    (cmd_err),
    .frame_err  (frame_err),
    .timeout    (timeout)
  );

  always #4 clk_125mhz = ~clk_125mhz;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk_125mhz) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge.
  int n_valid = 0, n_cerr = 0, n_ferr = 0, n_tmo = 0, n_wide = 0, n_bad = 0;
  int stb_cyc = 0, valid_cyc = 0, tmo_cyc = 0, tmo_dir = 0, tmo_duty = 0;
  logic p_v = 1'b0, p_ce = 1'b0, p_fe = 1'b0, p_to = 1'b0;
  always @(negedge clk_125mhz) begin
    if (dut.u_rx.byte_stb) stb_cyc <= cyc;
    if (cmd_valid) begin n_valid <= n_valid + 1; valid_cyc <= cyc; end
    if (cmd_err)   n_cerr <= n_cerr + 1;
    if (frame_err) n_ferr <= n_ferr + 1;
    if (timeout) begin
      n_tmo <= n_tmo + 1; tmo_cyc <= cyc; tmo_dir <= int'(direction); tmo_duty <= int'(duty);
    end
    if ((cmd_valid && p_v) || (cmd_err && p_ce) || (frame_err && p_fe) || (timeout && p_to))
      n_wide <= n_wide + 1;
    if (!$onehot(direction)) n_bad <= n_bad + 1;
    p_v <= cmd_valid; p_ce <= cmd_err; p_fe <= frame_err; p_to <= timeout;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: command rules applied to a whole received byte.
  int m_dir = 2, m_duty = 0;
  task automatic model_apply(input logic [7:0] b, input bit stop_ok, output int kind);
    kind = 0;
    if (!stop_ok) kind = 2;
    else if (b == "w" || b == "W") m_dir = 1;
    else if (b == "s" || b == "S") m_dir = 4;
    else if (b == "a" || b == "A") m_dir = 8;
    else if (b == "d" || b == "D") m_dir = 16;
    else if (b == " ")             m_dir = 2;
    else if (b == "q" || b == "Q") begin m_dir = 32; m_duty = (m_duty + STEP > 255) ? 255 : m_duty + STEP; end
    else if (b == "e" || b == "E") begin m_dir = 64; m_duty = (m_duty < STEP) ? 0 : m_duty - STEP; end
    else kind = 1;
  endtask

  int last_start = 0;
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    @(negedge clk_125mhz);
    rx_serial = 1'b0; last_start = cyc;
    repeat (CPB) @(negedge clk_125mhz);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      repeat (CPB) @(negedge clk_125mhz);
    end
    rx_serial = stop_ok;
    repeat (CPB) @(negedge clk_125mhz);
    rx_serial = 1'b1;
    repeat (CPB + 4) @(negedge clk_125mhz);
  endtask

  // Send one byte and compare pulse counts and outputs with expectations.
  task automatic frame_check(input string name, input logic [7:0] b, input bit stop_ok,
                             input int e_dir, input int e_duty, input int e_kind);
    int v0, c0, f0;
    v0 = n_valid; c0 = n_cerr; f0 = n_ferr;
    send_frame(b, stop_ok);
    chk({name, " cmd_valid"}, n_valid - v0, (e_kind == 0) ? 1 : 0);
    chk({name, " cmd_err"},   n_cerr - c0,  (e_kind == 1) ? 1 : 0);
    chk({name, " frame_err"}, n_ferr - f0,  (e_kind == 2) ? 1 : 0);
    chk({name, " direction"}, int'(direction), e_dir);
    chk({name, " duty"},      int'(duty), e_duty);
  endtask

  task automatic model_frame(input string name, input logic [7:0] b, input bit stop_ok, output int kind);
    model_apply(b, stop_ok, kind);
    frame_check(name, b, stop_ok, m_dir, m_duty, kind);
  endtask

  typedef struct {
    logic [7:0] b;
    bit         stop_ok;
    int         dir;
    int         duty;
    int         kind;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [7:0] b, input bit s, input int d, input int du, input int k);
    vec_t v;
    v.b = b; v.stop_ok = s; v.dir = d; v.duty = du; v.kind = k;
    tbl.push_back(v);
  endtask

  logic [7:0] cmds [7] = '{"w", "s", "a", "d", " ", "q", "e"};

  initial begin
    int kind, nonacc, t0, v0, lat, vcyc, target, w;
    logic [7:0] b;
    bit s;
    logic [7:0] ab;

    add("w", 1, 7'h01, 0, 0);
    for (int k = 1; k <= 17; k++) add("q", 1, 7'h20, (16 * k > 255) ? 255 : 16 * k, 0);
    for (int k = 1; k <= 17; k++) add("E", 1, 7'h40, (255 - 16 * k < 0) ? 0 : 255 - 16 * k, 0);
    add("x",   1, 7'h40, 0, 1);
    add("w",   0, 7'h40, 0, 2);
    add("S",   1, 7'h04, 0, 0);
    add(" ",   1, 7'h02, 0, 0);
    add("A",   1, 7'h08, 0, 0);
    add("Q",   1, 7'h20, 16, 0);
    add("D",   1, 7'h10, 16, 0);
    add(8'h00, 1, 7'h10, 16, 1);
    add("W",   1, 7'h01, 16, 0);
    add("e",   1, 7'h40, 0, 0);

    reset = 1'b1; rx_serial = 1'b1;
    repeat (5) @(negedge clk_125mhz);
    chk("reset direction", int'(direction), 7'h02);
    chk("reset duty", int'(duty), 0);
    chk("reset pulses", int'({cmd_valid, cmd_err, frame_err, timeout}), 0);
    reset = 1'b0;
    repeat (10) @(negedge clk_125mhz);

    foreach (tbl[i]) begin
      model_apply(tbl[i].b, tbl[i].stop_ok, kind);
      frame_check($sformatf("vec%0d", i), tbl[i].b, tbl[i].stop_ok, tbl[i].dir, tbl[i].duty, tbl[i].kind);
      if (i == 0) chk("strobe to cmd_valid", valid_cyc - stb_cyc, 1);
    end

    // Random bytes; an accepted command is forced often enough to keep the watchdog fed.
    nonacc = 0;
    t0 = n_tmo;
    for (int i = 0; i < 40; i++) begin
      s = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 9) < 6 || nonacc >= 5) begin
        b = cmds[$urandom_range(0, 6)];
        if (b >= "a" && b <= "z" && $urandom_range(0, 1) == 1) b = b - 8'd32;
        if (nonacc >= 5) s = 1'b1;
      end else begin
        b = 8'($urandom_range(0, 255));
      end
      model_frame($sformatf("rnd%0d", i), b, s, kind);
      nonacc = (kind == 0) ? 0 : nonacc + 1;
    end
    chk("no timeout while fed", n_tmo - t0, 0);

    // Watchdog expiry after silence.
    model_frame("pre-timeout q", "q", 1'b1, kind);
    model_frame("pre-timeout d", "d", 1'b1, kind);
    vcyc = valid_cyc;
    t0 = n_tmo; w = 0;
    while (n_tmo == t0 && w < 1500) begin @(negedge clk_125mhz); w++; end
    chk("timeout seen", n_tmo - t0, 1);
    chk("timeout latency", tmo_cyc - vcyc, TMO);
    chk("timeout direction", tmo_dir, 7'h02);
    chk("timeout duty", tmo_duty, 0);
    m_dir = 2; m_duty = 0;
    repeat (2500) @(negedge clk_125mhz);
    chk("no repeat timeout", n_tmo - t0, 1);
    chk("idle after timeout", int'(direction), 7'h02);

    // Short low glitch on the line.
    v0 = n_valid + n_cerr + n_ferr;
    @(negedge clk_125mhz); rx_serial = 1'b0;
    repeat (3) @(negedge clk_125mhz);
    rx_serial = 1'b1;
    repeat (60) @(negedge clk_125mhz);
    chk("glitch pulses", n_valid + n_cerr + n_ferr - v0, 0);
    chk("glitch direction", int'(direction), 7'h02);

    // Reset in the middle of data bit 4.
    model_frame("pre-reset q", "q", 1'b1, kind);
    ab = "w";
    v0 = n_valid + n_cerr + n_ferr;
    @(negedge clk_125mhz); rx_serial = 1'b0;
    repeat (CPB) @(negedge clk_125mhz);
    for (int i = 0; i < 4; i++) begin
      rx_serial = ab[i];
      repeat (CPB) @(negedge clk_125mhz);
    end
    rx_serial = ab[4];
    repeat (CPB / 2) @(negedge clk_125mhz);
    reset = 1'b1; rx_serial = 1'b1;
    repeat (3) @(negedge clk_125mhz);
    chk("midreset direction", int'(direction), 7'h02);
    chk("midreset duty", int'(duty), 0);
    reset = 1'b0;
    m_dir = 2; m_duty = 0;
    repeat (120) @(negedge clk_125mhz);
    chk("abandoned byte pulses", n_valid + n_cerr + n_ferr - v0, 0);
    model_frame("post-reset a", "a", 1'b1, kind);
    chk("post-reset a left", int'(direction), 7'h08);

    // Decode landing on the watchdog's final cycle.
    model_frame("pre-race d", "d", 1'b1, kind);
    vcyc = valid_cyc;
    lat  = valid_cyc - last_start;
    target = vcyc + TMO - lat;
    t0 = n_tmo; v0 = n_valid;
    while (cyc < target - 1) @(negedge clk_125mhz);
    send_frame("w", 1'b1);
    m_dir = 1;
    chk("race valid cycle", valid_cyc - vcyc, TMO);
    chk("race cmd_valid", n_valid - v0, 1);
    chk("race no timeout", n_tmo - t0, 0);
    chk("race direction", int'(direction), 7'h01);
    vcyc = valid_cyc; w = 0;
    while (n_tmo == t0 && w < 1500) begin @(negedge clk_125mhz); w++; end
    chk("restart timeout seen", n_tmo - t0, 1);
    chk("restart timeout latency", tmo_cyc - vcyc, TMO);

    chk("pulses one cycle wide", n_wide, 0);
    chk("direction always one-hot", n_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
